// File: rtl/top_level_synth.sv
// Frequency-locked ramp generator: measures the infreq period in clk cycles, divides it
// by n on request (adj) and steps an OUT_W-bit ramp every L = P/n clk cycles.
module top_level_synth #(
    parameter int CNT_W = 16,
    parameter int OUT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             adj,
    input  logic             infreq,
    input  logic [2:0]       n,
    output logic [OUT_W-1:0] out
);
    localparam int BIT_W = $clog2(CNT_W + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {IDLE, ARM, COUNT, DIVIDE} state_t;

    state_t             state_q, state_d;
    logic [2:0]         sync_q, sync_d;
    logic               adj_q, adj_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   quo_q, quo_d;
    logic [CNT_W-1:0]   rem_q, rem_d;
    logic [CNT_W-1:0]   div_q, div_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [CNT_W-1:0]   l_q, l_d;
    logic [CNT_W-1:0]   tick_q, tick_d;
    logic [OUT_W-1:0]   out_q, out_d;

    logic               ref_rise, adj_rise, q_bit, load_l;
    logic [CNT_W-1:0]   trial, quo_next, l_new;

    always_comb begin
        state_d  = state_q;
        sync_d   = {sync_q[1:0], infreq};
        adj_d    = adj;
        cnt_d    = cnt_q;
        quo_d    = quo_q;
        rem_d    = rem_q;
        div_d    = div_q;
        bit_d    = bit_q;
        l_d      = l_q;
        tick_d   = tick_q;
        out_d    = out_q;
        load_l   = 1'b0;
        l_new    = l_q;

        // sync_q[1] is the second synchronizer flop, sync_q[2] its previous value
        ref_rise = sync_q[1] & ~sync_q[2];
        adj_rise = adj & ~adj_q;

        // Restoring divide step: shift the next dividend bit into the remainder
        trial    = {rem_q[CNT_W-2:0], quo_q[CNT_W-1]};
        q_bit    = (trial >= div_q);
        quo_next = {quo_q[CNT_W-2:0], q_bit};

        case (state_q)
            IDLE: begin
                if (adj_rise) begin
                    state_d = ARM;
                    cnt_d   = '0;
                end
            end
            ARM: begin
                if (ref_rise) begin
                    state_d = COUNT;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            COUNT: begin
                if (cnt_q == CNT_MAX) begin
                    state_d = IDLE;
                end else if (ref_rise) begin
                    // The edge that closes the period is itself counted
                    state_d = DIVIDE;
                    quo_d   = cnt_q + 1'b1;
                    rem_d   = '0;
                    bit_d   = '0;
                    div_d   = (n == 3'd0) ? CNT_W'(1) : CNT_W'(n);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DIVIDE: begin
                rem_d = q_bit ? (trial - div_q) : trial;
                quo_d = quo_next;
                bit_d = bit_q + 1'b1;
                if (bit_q == BIT_W'(CNT_W - 1)) begin
                    load_l  = 1'b1;
                    l_new   = (quo_next == '0) ? CNT_W'(1) : quo_next;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Ramp: out advances once every L cycles; a fresh L restarts the interval
        if (load_l) begin
            l_d    = l_new;
            tick_d = '0;
        end else if (l_q == '0) begin
            tick_d = '0;
        end else if (tick_q == l_q - 1'b1) begin
            tick_d = '0;
            out_d  = out_q + 1'b1;
        end else begin
            tick_d = tick_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sync_q  <= '0;
            adj_q   <= 1'b0;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            div_q   <= '0;
            bit_q   <= '0;
            l_q     <= '0;
            tick_q  <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            adj_q   <= adj_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            l_q     <= l_d;
            tick_q  <= tick_d;
            out_q   <= out_d;
        end
    end

    assign out = out_q;

endmodule

// File: tb/tb_top_level_synth.sv
// Directed bench for top_level_synth: calibrates against a 10-cycle infreq period and
// checks the ramp step interval, timeout, ignored adj, mid-calibration reset and wrap.
module tb_top_level_synth;
    localparam int CNT_W = 10;
    localparam int OUT_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             adj = 1'b0;
    logic             infreq = 1'b0;
    logic [2:0]       n = 3'd0;
    logic [OUT_W-1:0] out;
    logic             ref_en = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    top_level_synth #(.CNT_W(CNT_W), .OUT_W(OUT_W)) dut (
        .clk(clk), .rst(rst), .adj(adj), .infreq(infreq), .n(n), .out(out)
    );

    always #10 clk = ~clk;

    // 200 ns period = 10 clk cycles; edges sit away from clk edges
    initial begin
        #5;
        forever begin
            #100;
            if (ref_en) infreq = ~infreq;
        end
    end

    task automatic pulse_adj();
        @(negedge clk); adj = 1'b1;
        @(negedge clk); adj = 1'b0;
    endtask

    task automatic calibrate(input logic [2:0] nv);
        @(negedge clk); n = nv;
        pulse_adj();
        repeat (60) @(negedge clk);
    endtask

    // Cycles between two consecutive changes of out; -1 if none within the bound
    task automatic measure(output int iv);
        logic [OUT_W-1:0] v;
        int c;
        iv = -1;
        v = out; c = 0;
        while (out == v && c < 200) begin @(negedge clk); c++; end
        if (c < 200) begin
            v = out; c = 0;
            while (out == v && c < 200) begin @(negedge clk); c++; end
            if (c < 200) iv = c;
        end
    endtask

    task automatic check_iv(input string name, input int exp);
        int iv;
        measure(iv);
        n_checks++;
        if (iv !== exp) begin
            n_fail++;
            $display("FAIL %s: interval %0d, expected %0d", name, iv, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (out !== 8'd0) begin n_fail++; $display("FAIL reset_out: got %0d, expected 0", out); end
        repeat (40) @(negedge clk);
        n_checks++;
        if (out !== 8'd0) begin n_fail++; $display("FAIL reset_hold: got %0d, expected 0", out); end
    endtask

    task automatic test_n2();
        logic [OUT_W-1:0] v0, dv;
        calibrate(3'd2);
        check_iv("n2_interval", 5);
        check_iv("n2_interval2", 5);
        v0 = out;
        repeat (50) @(negedge clk);
        dv = out - v0;
        n_checks++;
        if (dv !== 8'd10) begin n_fail++; $display("FAIL n2_steps: got %0d, expected 10", dv); end
    endtask

    task automatic test_n3_n4();
        calibrate(3'd3);
        check_iv("n3_interval", 3);
        calibrate(3'd4);
        check_iv("n4_interval", 2);
    endtask

    task automatic test_n0_timeout();
        calibrate(3'd0);
        check_iv("n0_interval", 10);
        ref_en = 1'b0;
        repeat (30) @(negedge clk);
        calibrate(3'd2);
        repeat (1100) @(negedge clk);
        check_iv("timeout_keeps_l", 10);
        ref_en = 1'b1;
        repeat (30) @(negedge clk);
        calibrate(3'd4);
        check_iv("after_timeout", 2);
    endtask

    task automatic test_adj_ignored_and_rst();
        @(negedge clk); n = 3'd3;
        pulse_adj();
        repeat (12) @(negedge clk);
        pulse_adj();
        repeat (60) @(negedge clk);
        check_iv("adj_ignored", 3);
        pulse_adj();
        repeat (12) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (out !== 8'd0) begin n_fail++; $display("FAIL mid_rst_out: got %0d, expected 0", out); end
        repeat (60) @(negedge clk);
        n_checks++;
        if (out !== 8'd0) begin n_fail++; $display("FAIL mid_rst_hold: got %0d, expected 0", out); end
    endtask

    task automatic test_l1_wrap();
        logic [OUT_W-1:0] prev;
        int bad = 0;
        bit wrapped = 0;
        calibrate(3'd7);
        check_iv("l1_interval", 1);
        prev = out;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (out !== OUT_W'(prev + 1'b1)) bad++;
            if (prev == 8'd255 && out == 8'd0) wrapped = 1;
            prev = out;
        end
        n_checks++;
        if (bad != 0 || !wrapped) begin
            n_fail++;
            $display("FAIL l1_wrap: bad_steps %0d wrapped %0d, expected 0 and 1", bad, wrapped);
        end
    endtask

    initial begin
        test_reset();
        test_n2();
        test_n3_n4();
        test_n0_timeout();
        test_adj_ignored_and_rst();
        test_l1_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
